// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter: state and parity encodings,
// oversampling factor and the bit-period reload value.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} tx_state_t;
    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_RSVD} parity_t;

    localparam int OVERSAMPLE = 8;
    localparam int PCNT_W     = 19;

    // Reload value P-1 for P = max(prescale,1)*8; the low three bits of P-1 are always ones.
    function automatic logic [PCNT_W-1:0] period_m1(input logic [15:0] prescale);
        logic [15:0] ps;
        ps = (prescale == 16'd0) ? 16'd1 : prescale;
        return {ps - 16'd1, 3'b111};
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: down-counts from the loaded P-1 and flags the last clock of the
// period; 'double' stretches the period to 2P by running the count a second time.
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              double,
    input  logic [PCNT_W-1:0] load_val,
    output logic              tick
);

    logic [PCNT_W-1:0] cnt_q, cnt_d;
    logic [PCNT_W-1:0] period_q, period_d;
    logic              second_q, second_d;

    // Tick depends only on flops so the FSM can use it to decide a reload.
    assign tick = (cnt_q == '0) && !second_q;

    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        second_d = second_q;
        if (load) begin
            cnt_d    = load_val;
            period_d = load_val;
            second_d = double;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else if (second_q) begin
            cnt_d    = period_q;
            second_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            period_q <= '0;
            second_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            second_q <= second_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// AXI4-Stream to UART serialiser with per-character frame format (5..DATA_WIDTH data
// bits, none/even/odd parity, 1 or 2 stop bits). Define UART_TX_BREAK_EN for break_req.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  txd,
    output logic                  busy,
    input  logic [15:0]           prescale,
    input  logic [3:0]            cfg_data_bits,
    input  logic [1:0]            cfg_parity,
`ifdef UART_TX_BREAK_EN
    input  logic                  break_req,
`endif
    input  logic                  cfg_stop2
);

    localparam int BCNT_W = $clog2(DATA_WIDTH + 1);

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BCNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  stop2_q, stop2_d;
    logic [15:0]           prescale_q, prescale_d;
    logic                  txd_q, txd_d;
    logic                  tready_q, tready_d;
    logic                  busy_q, busy_d;
`ifdef UART_TX_BREAK_EN
    logic                  brk_rec_q, brk_rec_d;
`endif

    logic                  tick, load, double;
    logic [PCNT_W-1:0]     load_val;
    logic [3:0]            data_n;
    logic [DATA_WIDTH-1:0] data_mask, data_masked;
    parity_t               cfg_par;

    assign cfg_par       = parity_t'(cfg_parity);
    assign s_axis_tready = tready_q;
    assign txd           = txd_q;
    assign busy          = busy_q;

    always_comb begin
        data_n = cfg_data_bits;
        if (cfg_data_bits < 4'd5)
            data_n = 4'd5;
        else if (cfg_data_bits > 4'(DATA_WIDTH))
            data_n = 4'(DATA_WIDTH);
        for (int i = 0; i < DATA_WIDTH; i++)
            data_mask[i] = (4'(i) < data_n);
    end

    assign data_masked = s_axis_tdata & data_mask;

    uart_baud_tick u_baud (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .double   (double),
        .load_val (load_val),
        .tick     (tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        prescale_d = prescale_q;
        txd_d      = txd_q;
        tready_d   = tready_q;
        busy_d     = busy_q;
        load       = 1'b0;
        double     = 1'b0;
        load_val   = period_m1(prescale_q);
`ifdef UART_TX_BREAK_EN
        brk_rec_d  = brk_rec_q;
`endif
        case (state_q)
            IDLE: begin
                // An advertised tready is always honoured, so accept beats a same-edge break.
                if (tready_q && s_axis_tvalid) begin
                    state_d    = START;
                    shift_d    = data_masked;
                    bit_cnt_d  = BCNT_W'(data_n - 4'd1);
                    par_en_d   = (cfg_par == PAR_EVEN) || (cfg_par == PAR_ODD);
                    par_bit_d  = (^data_masked) ^ (cfg_par == PAR_ODD);
                    stop2_d    = cfg_stop2;
                    prescale_d = prescale;
                    txd_d      = 1'b0;
                    tready_d   = 1'b0;
                    busy_d     = 1'b1;
                    load       = 1'b1;
                    load_val   = period_m1(prescale);
`ifdef UART_TX_BREAK_EN
                end else if (break_req) begin
                    state_d   = BRK;
                    brk_rec_d = 1'b0;
                    txd_d     = 1'b0;
                    tready_d  = 1'b0;
                    busy_d    = 1'b1;
`endif
                end else begin
                    tready_d = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    load    = 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    load = 1'b1;
                    if (bit_cnt_q != '0) begin
                        txd_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end else if (par_en_q) begin
                        state_d = PARITY;
                        txd_d   = par_bit_q;
                    end else begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                        double  = stop2_q;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                    load    = 1'b1;
                    double  = stop2_q;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d  = IDLE;
                    tready_d = 1'b1;
                    busy_d   = 1'b0;
                end
            end
`ifdef UART_TX_BREAK_EN
            BRK: begin
                // Hold low while requested, then one idle-high period before reopening.
                if (!brk_rec_q) begin
                    if (!break_req) begin
                        brk_rec_d = 1'b1;
                        txd_d     = 1'b1;
                        load      = 1'b1;
                        load_val  = period_m1(prescale);
                    end
                end else if (tick) begin
                    state_d  = IDLE;
                    tready_d = 1'b1;
                    busy_d   = 1'b0;
                end
            end
`endif
            default: begin
                state_d  = IDLE;
                txd_d    = 1'b1;
                tready_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            prescale_q <= '0;
            txd_q      <= 1'b1;
            tready_q   <= 1'b0;
            busy_q     <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_rec_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            prescale_q <= prescale_d;
            txd_q      <= txd_d;
            tready_q   <= tready_d;
            busy_q     <= busy_d;
`ifdef UART_TX_BREAK_EN
            brk_rec_q  <= brk_rec_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: hand-computed line patterns checked every clock,
// plus reset, back-to-back, mid-frame reset and (with UART_TX_BREAK_EN) break cases.
module tb_uart_tx_frame;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        txd;
    logic        busy;
    logic [15:0] prescale;
    logic [3:0]  cfg_data_bits;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic        break_req;

    int  n_vec = 0;
    int  n_err = 0;
    time t_acc;
    time t_first;

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .txd           (txd),
        .busy          (busy),
        .prescale      (prescale),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
`ifdef UART_TX_BREAK_EN
        .break_req     (break_req),
`endif
        .cfg_stop2     (cfg_stop2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    // Raise tvalid and wait for the edge that completes the handshake.
    task automatic do_accept(input string tag);
        logic seen;
        seen = 1'b0;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 500 && !seen; i++) begin
            seen = s_axis_tready;
            @(posedge clk);
            t_acc = $time;
            #1;
        end
        if (!seen)
            chk({tag, "_accept_timeout"}, {31'd0, seen}, 32'd1);
    endtask

    // exp[k] is the line level of slot k (start, data, parity, stop slots) in send order.
    task automatic check_bits(input string tag, input logic [15:0] exp, input int nslots,
                              input int p, input bit mid_change);
        for (int k = 0; k < nslots * p; k++) begin
            chk($sformatf("%s_txd_k%0d", tag, k), {31'd0, txd}, {31'd0, exp[k / p]});
            chk($sformatf("%s_busy_k%0d", tag, k), {31'd0, busy}, 32'd1);
            chk($sformatf("%s_tready_k%0d", tag, k), {31'd0, s_axis_tready}, 32'd0);
            if (mid_change && k == 3 * p) begin
                prescale      = 16'd3;
                cfg_data_bits = 4'd5;
                cfg_parity    = 2'd2;
                cfg_stop2     = 1'b1;
            end
            if (mid_change && k == nslots * p - 4) begin
                prescale      = 16'd1;
                cfg_data_bits = 4'd8;
                cfg_parity    = 2'd0;
                cfg_stop2     = 1'b0;
            end
            tick1();
        end
    endtask

    task automatic check_end(input string tag);
        chk({tag, "_end_txd"}, {31'd0, txd}, 32'd1);
        chk({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_end_tready"}, {31'd0, s_axis_tready}, 32'd1);
    endtask

    task automatic set_cfg(input logic [15:0] ps, input logic [3:0] nb, input logic [1:0] par,
                           input logic st2, input logic [7:0] data);
        prescale      = ps;
        cfg_data_bits = nb;
        cfg_parity    = par;
        cfg_stop2     = st2;
        s_axis_tdata  = data;
    endtask

    initial begin
        rst           = 1'b1;
        s_axis_tvalid = 1'b0;
        break_req     = 1'b0;
        set_cfg(16'd1, 4'd8, 2'd0, 1'b0, 8'h00);
        repeat (3) tick1();
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_tready", {31'd0, s_axis_tready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick1();
        chk("post_rst_tready", {31'd0, s_axis_tready}, 32'd1);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        // 8N1 0x55 at 8 clk/bit
        set_cfg(16'd1, 4'd8, 2'd0, 1'b0, 8'h55);
        do_accept("t1");
        s_axis_tvalid = 1'b0;
        check_bits("t1", 16'h02AA, 10, 8, 1'b0);
        check_end("t1");

        // 7E2 0xC3 at 16 clk/bit: 1100001, parity 1, two stop slots
        set_cfg(16'd2, 4'd7, 2'd1, 1'b1, 8'hC3);
        do_accept("t2");
        s_axis_tvalid = 1'b0;
        check_bits("t2", 16'h0786, 11, 16, 1'b0);
        check_end("t2");

        // 8O1 0xFF -> parity 1; 8E1 0xFF -> parity 0
        set_cfg(16'd1, 4'd8, 2'd2, 1'b0, 8'hFF);
        do_accept("t3o");
        s_axis_tvalid = 1'b0;
        check_bits("t3o", 16'h07FE, 11, 8, 1'b0);
        check_end("t3o");
        set_cfg(16'd1, 4'd8, 2'd1, 1'b0, 8'hFF);
        do_accept("t3e");
        s_axis_tvalid = 1'b0;
        check_bits("t3e", 16'h05FE, 11, 8, 1'b0);
        check_end("t3e");

        // data_bits=2 clamps to 5; reserved parity behaves as none
        set_cfg(16'd1, 4'd2, 2'd3, 1'b0, 8'h35);
        do_accept("tcl");
        s_axis_tvalid = 1'b0;
        check_bits("tcl", 16'h006A, 7, 8, 1'b0);
        check_end("tcl");

        // back-to-back with tvalid held, cfg disturbed during the first frame
        set_cfg(16'd1, 4'd8, 2'd0, 1'b0, 8'hA5);
        do_accept("t4a");
        t_first = t_acc;
        s_axis_tdata = 8'h3C;
        check_bits("t4a", 16'h034A, 10, 8, 1'b1);
        check_end("t4a");
        do_accept("t4b");
        chk("t4_start_gap", 32'(t_acc - t_first), 32'd810);
        s_axis_tvalid = 1'b0;
        check_bits("t4b", 16'h0278, 10, 8, 1'b0);
        check_end("t4b");

        // prescale=0 acts as 1; reset during data bit 3
        set_cfg(16'd0, 4'd8, 2'd0, 1'b0, 8'hA5);
        do_accept("t5");
        s_axis_tvalid = 1'b0;
        check_bits("t5", 16'h000A, 4, 8, 1'b0);
        rst = 1'b1;
        tick1();
        chk("t5_rst_txd", {31'd0, txd}, 32'd1);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_tready", {31'd0, s_axis_tready}, 32'd0);
        rst = 1'b0;
        tick1();
        chk("t5_rel_tready", {31'd0, s_axis_tready}, 32'd1);
        chk("t5_rel_txd", {31'd0, txd}, 32'd1);

`ifdef UART_TX_BREAK_EN
        // break for 100 clk, then one idle period of 8 clk before accepting again
        set_cfg(16'd1, 4'd8, 2'd0, 1'b0, 8'h55);
        break_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick1();
            chk($sformatf("t6_brk_txd_%0d", i), {31'd0, txd}, 32'd0);
            chk($sformatf("t6_brk_tready_%0d", i), {31'd0, s_axis_tready}, 32'd0);
            chk($sformatf("t6_brk_busy_%0d", i), {31'd0, busy}, 32'd1);
        end
        break_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick1();
            chk($sformatf("t6_rec_txd_%0d", i), {31'd0, txd}, 32'd1);
            chk($sformatf("t6_rec_tready_%0d", i), {31'd0, s_axis_tready}, 32'd0);
        end
        tick1();
        chk("t6_reopen_tready", {31'd0, s_axis_tready}, 32'd1);
        do_accept("t6");
        s_axis_tvalid = 1'b0;
        check_bits("t6", 16'h02AA, 10, 8, 1'b0);
        check_end("t6");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
